coffee_payment_selector: RTL and testbench
==========================================

Name: coffee_payment_selector

Overview:
- Upstream stage of the coffee brewer; the brewer consumes cofeeSelection[3:0] one-hot (bit0 expresso, bit1 latte, bit2 cappuccino, bit3 mocca).
- Accumulates coin credit and validates a drink button press against its price.
- Holds the one-hot selection to the brewer until the brewer signals completion, then pays out the remaining credit as change.

Parameters:
- CREDIT_W, 8, width of credit and change counters.
- MAX_CREDIT, 50, maximum accepted credit in units; must be < 2^CREDIT_W.
- PRICE_EXPRESSO, 10, price in units.
- PRICE_LATTE, 15, price in units.
- PRICE_CAPPUCCINO, 15, price in units.
- PRICE_MOCCA, 20, price in units.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset_n  in  1  synchronous active-low reset.
- coinValid  in  1  one-cycle pulse; a coin is present.
- coinValue  in  2  coin code: 00=1, 01=2, 10=5, 11=10 units.
- buttonSel  in  4  drink buttons, same bit order as cofeeSelection.
- brewDone  in  1  one-cycle pulse from the brewer; drink finished.
- cofeeSelection  out  4  one-hot drink request to the brewer; 0 when none.
- busy  out  1  high in DISPENSE and CHANGE.
- credit  out  CREDIT_W  current credit, for display.
- coinReject  out  1  one-cycle pulse; the coin was not accepted.
- lowCredit  out  1  one-cycle pulse; the selection was refused for insufficient credit.
- changeValid  out  1  one-cycle pulse; changeAmount is valid.
- changeAmount  out  CREDIT_W  change paid out; held until the next changeValid.

Behaviour:
- Reset: when Reset_n=0 at a rising edge, state=IDLE and every output is 0. Reset applies in any state, including mid-DISPENSE: no change is paid and credit is lost.
- All outputs are registered; every response appears on the cycle after its triggering input edge.
- States: IDLE, DISPENSE, CHANGE.

IDLE:
- Valid selection: buttonSel has exactly one bit set and credit >= its price.
  - Next cycle: state=DISPENSE, cofeeSelection=buttonSel, credit -= price.
  - A coinValid in the same cycle is rejected (coinReject pulse); the selection has priority.
- Selection with insufficient credit: lowCredit pulses; state and credit are unchanged. A coin in the same cycle is still processed.
- buttonSel with zero bits or more than one bit set: ignored, no pulse.
- coinValid with no valid selection:
  - If credit + value <= MAX_CREDIT, credit += value (sum computed at CREDIT_W+1 bits, no wrap).
  - Otherwise coinReject pulses and credit is unchanged.
  - credit == MAX_CREDIT exactly is accepted.

DISPENSE:
- cofeeSelection is held constant.
- buttonSel is ignored; every coinValid produces a coinReject pulse.
- brewDone: next cycle cofeeSelection=0 and state=CHANGE.
- No timeout; the block waits for brewDone indefinitely.
- brewDone outside DISPENSE is ignored.

CHANGE (one cycle):
- If credit > 0: changeValid=1, changeAmount=credit, credit=0.
- If credit == 0: no pulse; changeAmount keeps its old value.
- Next state is always IDLE.
- A coinValid in CHANGE is rejected.

Invariants:
- cofeeSelection is either 0 or exactly one-hot.
- credit <= MAX_CREDIT at all times.

Optional Feature:
- Macro: COFFEE_REFUND_EN.
- When defined, adds input port refundReq (1 bit).
  - In IDLE with credit > 0, refundReq causes next cycle: changeValid=1, changeAmount=credit, credit=0; the state remains IDLE.
  - refundReq has priority over buttonSel and coinValid in the same cycle; the coin is rejected.
  - refundReq is ignored in DISPENSE and CHANGE, and in IDLE when credit=0.
- When not defined: no refundReq port, and credit is returned only through CHANGE after a brew.

Test Plan:
- Reset_n=0 for 2 cycles while coinValid=1 -> all outputs 0, state IDLE, credit 0.
- Coins 10, 5, 2 (codes 11, 10, 01), then buttonSel=0010 -> credit reads 10, 15, 17; next cycle cofeeSelection=0010, credit=2, busy=1; brewDone pulse -> cofeeSelection=0, then changeValid=1 with changeAmount=2, then IDLE with credit 0.
- Credit 5, buttonSel=1000 -> lowCredit pulse, credit stays 5, cofeeSelection stays 0; buttonSel=0011 with credit 20 -> ignored, no pulse.
- Credit 45: coin 5 -> credit 50; coin 1 -> coinReject pulse, credit stays 50.
- In DISPENSE, coinValid code 11 -> coinReject pulse, credit unchanged. buttonSel=0001 and coinValid in the same IDLE cycle with credit 10 -> drink accepted, coinReject pulse, credit 0. Credit 0 at CHANGE -> no changeValid pulse.
- COFFEE_REFUND_EN, credit 17, refundReq=1 together with buttonSel=0001 -> changeValid with changeAmount=17, credit 0, no dispense. Reset_n=0 during DISPENSE -> cofeeSelection=0 next cycle and no changeValid.

Source files
------------

// File: rtl/coffee_payment_selector.sv
// -----------------------------------------------------------------------------
// coffee_payment_selector
//
// Payment front-end of the coffee brewer. Accumulates coin credit, validates a
// one-hot drink button press against that drink's price, holds the one-hot
// selection to the brewer until it reports completion, then pays out whatever
// credit remains as change.
//
// Optional feature (compile-time macro COFFEE_REFUND_EN):
//   adds the refundReq input; in IDLE with non-zero credit it returns the whole
//   credit as change without brewing. Without the macro the port is absent and
//   credit only leaves through the CHANGE state after a brew.
//
// Ports
//   Clock           in   system clock, all state on the rising edge
//   Reset_n         in   synchronous active-low reset
//   coinValid       in   one-cycle pulse, a coin is present
//   coinValue[1:0]  in   coin code 00=1, 01=2, 10=5, 11=10 units
//   buttonSel[3:0]  in   drink buttons (bit0 expresso, bit1 latte,
//                        bit2 cappuccino, bit3 mocca)
//   brewDone        in   one-cycle pulse from the brewer, drink finished
//   refundReq       in   (COFFEE_REFUND_EN only) return credit from IDLE
//   cofeeSelection  out  one-hot drink request to the brewer, 0 when none
//   busy            out  high in DISPENSE and CHANGE
//   credit          out  current credit for display
//   coinReject      out  one-cycle pulse, coin not accepted
//   lowCredit       out  one-cycle pulse, selection refused (price > credit)
//   changeValid     out  one-cycle pulse, changeAmount is valid
//   changeAmount    out  change paid out, held until the next changeValid
//   o_dbg_state     out  current FSM state (0 IDLE, 1 DISPENSE, 2 CHANGE)
//
// Handshakes: there is no back-pressure anywhere. Every input is a sampled
// level or one-cycle pulse and every output pulse lasts exactly one cycle,
// appearing on the cycle after the rising edge that sampled its cause.
// -----------------------------------------------------------------------------
module coffee_payment_selector #(
    parameter int unsigned CREDIT_W         = 8,
    parameter int unsigned MAX_CREDIT       = 50,
    parameter int unsigned PRICE_EXPRESSO   = 10,
    parameter int unsigned PRICE_LATTE      = 15,
    parameter int unsigned PRICE_CAPPUCCINO = 15,
    parameter int unsigned PRICE_MOCCA      = 20
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                coinValid,
    input  logic [1:0]          coinValue,
    input  logic [3:0]          buttonSel,
    input  logic                brewDone,
`ifdef COFFEE_REFUND_EN
    input  logic                refundReq,
`endif
    output logic [3:0]          cofeeSelection,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit,
    output logic                coinReject,
    output logic                lowCredit,
    output logic                changeValid,
    output logic [CREDIT_W-1:0] changeAmount,
    output logic [1:0]          o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        CHANGE   = 2'd2
    } state_t;

    localparam logic [CREDIT_W-1:0] P_EXPRESSO   = CREDIT_W'(PRICE_EXPRESSO);
    localparam logic [CREDIT_W-1:0] P_LATTE      = CREDIT_W'(PRICE_LATTE);
    localparam logic [CREDIT_W-1:0] P_CAPPUCCINO = CREDIT_W'(PRICE_CAPPUCCINO);
    localparam logic [CREDIT_W-1:0] P_MOCCA      = CREDIT_W'(PRICE_MOCCA);
    // One bit wider than the credit so a coin on top of near-full credit
    // cannot wrap before it is compared against the ceiling.
    localparam logic [CREDIT_W:0]   MAX_SUM      = (CREDIT_W+1)'(MAX_CREDIT);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                r_state;
    logic [CREDIT_W-1:0]   r_credit;
    logic [3:0]            r_sel;
    logic                  r_coin_reject;
    logic                  r_low_credit;
    logic                  r_change_valid;
    logic [CREDIT_W-1:0]   r_change_amount;

    // ------------------------------------------------------------------
    // Next values
    // ------------------------------------------------------------------
    state_t                w_state_next;
    logic [CREDIT_W-1:0]   w_credit_next;
    logic [3:0]            w_sel_next;
    logic                  w_coin_reject_next;
    logic                  w_low_credit_next;
    logic                  w_change_valid_next;
    logic [CREDIT_W-1:0]   w_change_amount_next;

    // ------------------------------------------------------------------
    // Input decode shared by next-state and output logic
    // ------------------------------------------------------------------
    logic                  w_btn_onehot;
    logic [CREDIT_W-1:0]   w_price;
    logic                  w_sel_valid;
    logic                  w_sel_low;
    logic [CREDIT_W-1:0]   w_coin_units;
    logic [CREDIT_W:0]     w_coin_sum;
    logic                  w_coin_fits;
    logic                  w_refund;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves 0.
    assign w_btn_onehot = (buttonSel != 4'd0) &&
                          ((buttonSel & (buttonSel - 4'd1)) == 4'd0);

    always_comb begin
        w_price = P_EXPRESSO;
        unique case (buttonSel)
            4'b0001: w_price = P_EXPRESSO;
            4'b0010: w_price = P_LATTE;
            4'b0100: w_price = P_CAPPUCCINO;
            4'b1000: w_price = P_MOCCA;
            default: w_price = P_EXPRESSO;  // only consulted when one-hot
        endcase
    end

    assign w_sel_valid = w_btn_onehot && (r_credit >= w_price);
    assign w_sel_low   = w_btn_onehot && (r_credit <  w_price);

    always_comb begin
        w_coin_units = CREDIT_W'(1);
        case (coinValue)
            2'b00:   w_coin_units = CREDIT_W'(1);
            2'b01:   w_coin_units = CREDIT_W'(2);
            2'b10:   w_coin_units = CREDIT_W'(5);
            default: w_coin_units = CREDIT_W'(10);
        endcase
    end

    assign w_coin_sum  = {1'b0, r_credit} + {1'b0, w_coin_units};
    assign w_coin_fits = (w_coin_sum <= MAX_SUM);

`ifdef COFFEE_REFUND_EN
    // A refund with nothing to refund is treated as if it were not pressed.
    assign w_refund = refundReq && (r_credit != '0);
`else
    assign w_refund = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Process 1: state and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_state         <= IDLE;
            r_credit        <= '0;
            r_sel           <= 4'd0;
            r_coin_reject   <= 1'b0;
            r_low_credit    <= 1'b0;
            r_change_valid  <= 1'b0;
            r_change_amount <= '0;
        end else begin
            r_state         <= w_state_next;
            r_credit        <= w_credit_next;
            r_sel           <= w_sel_next;
            r_coin_reject   <= w_coin_reject_next;
            r_low_credit    <= w_low_credit_next;
            r_change_valid  <= w_change_valid_next;
            r_change_amount <= w_change_amount_next;
        end
    end

    // ------------------------------------------------------------------
    // Process 2: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                // A refund keeps us in IDLE even if a valid drink is pressed.
                if (!w_refund && w_sel_valid) begin
                    w_state_next = DISPENSE;
                end
            end
            DISPENSE: begin
                // Deliberately no timeout: the brewer owns the brew duration.
                if (brewDone) begin
                    w_state_next = CHANGE;
                end
            end
            CHANGE:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Process 3: output / datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        w_credit_next        = r_credit;
        w_sel_next           = r_sel;
        w_coin_reject_next   = 1'b0;
        w_low_credit_next    = 1'b0;
        w_change_valid_next  = 1'b0;
        w_change_amount_next = r_change_amount;

        unique case (r_state)
            IDLE: begin
                if (w_refund) begin
                    w_change_valid_next  = 1'b1;
                    w_change_amount_next = r_credit;
                    w_credit_next        = '0;
                    w_coin_reject_next   = coinValid;
                end else if (w_sel_valid) begin
                    w_sel_next         = buttonSel;
                    w_credit_next      = r_credit - w_price;
                    // The purchase wins; a simultaneous coin goes back out.
                    w_coin_reject_next = coinValid;
                end else begin
                    w_low_credit_next = w_sel_low;
                    // A refused or malformed selection does not block the coin.
                    if (coinValid) begin
                        if (w_coin_fits) begin
                            w_credit_next = w_coin_sum[CREDIT_W-1:0];
                        end else begin
                            w_coin_reject_next = 1'b1;
                        end
                    end
                end
            end
            DISPENSE: begin
                w_coin_reject_next = coinValid;
                if (brewDone) begin
                    w_sel_next = 4'd0;
                end
            end
            CHANGE: begin
                w_coin_reject_next = coinValid;
                // With nothing left, changeAmount keeps the last payout.
                if (r_credit != '0) begin
                    w_change_valid_next  = 1'b1;
                    w_change_amount_next = r_credit;
                    w_credit_next        = '0;
                end
            end
            default: begin
                w_sel_next    = 4'd0;
                w_credit_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: all straight from registers
    // ------------------------------------------------------------------
    assign cofeeSelection = r_sel;
    assign busy           = (r_state != IDLE);
    assign credit         = r_credit;
    assign coinReject     = r_coin_reject;
    assign lowCredit      = r_low_credit;
    assign changeValid    = r_change_valid;
    assign changeAmount   = r_change_amount;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_coffee_payment_selector.sv
module tb_coffee_payment_selector;

  localparam int CW = 8;
  localparam int EW = CW + 2;

  localparam logic [1:0] K_REJ = 2'd1;
  localparam logic [1:0] K_LOW = 2'd2;
  localparam logic [1:0] K_CHG = 2'd3;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DISPENSE = 2'd1;
  localparam logic [1:0] S_CHANGE   = 2'd2;

  // ---------------- clock / reset ----------------
  logic          Clock = 1'b0;
  logic          Reset_n;
  logic          coinValid;
  logic [1:0]    coinValue;
  logic [3:0]    buttonSel;
  logic          brewDone;
  logic          refundReq;
  logic [3:0]    cofeeSelection;
  logic          busy;
  logic [CW-1:0] credit;
  logic          coinReject;
  logic          lowCredit;
  logic          changeValid;
  logic [CW-1:0] changeAmount;
  logic [1:0]    o_dbg_state;

  always #5 Clock = ~Clock;

  coffee_payment_selector dut (
    .Clock          (Clock),
    .Reset_n        (Reset_n),
    .coinValid      (coinValid),
    .coinValue      (coinValue),
    .buttonSel      (buttonSel),
    .brewDone       (brewDone),
`ifdef COFFEE_REFUND_EN
    .refundReq      (refundReq),
`endif
    .cofeeSelection (cofeeSelection),
    .busy           (busy),
    .credit         (credit),
    .coinReject     (coinReject),
    .lowCredit      (lowCredit),
    .changeValid    (changeValid),
    .changeAmount   (changeAmount),
    .o_dbg_state    (o_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Event word: {kind, value}; value is credit for reject/low, amount for change.
  task automatic expect_ev(input logic [1:0] kind, input int value);
    exp_q.push_back({kind, value[CW-1:0]});
  endtask

  task automatic observe(input logic [EW-1:0] got);
    logic [EW-1:0] want;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d value %0d, expected no event",
               got[EW-1:CW], got[CW-1:0]);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        errors++;
        $display("FAIL event: got kind %0d value %0d expected kind %0d value %0d",
                 got[EW-1:CW], got[CW-1:0], want[EW-1:CW], want[CW-1:0]);
      end
    end
  endtask

  // Monitor: pops whenever the DUT presents a pulse, sampled mid-cycle.
  always @(negedge Clock) begin
    if (coinReject === 1'b1)  observe({K_REJ, credit});
    if (lowCredit === 1'b1)   observe({K_LOW, credit});
    if (changeValid === 1'b1) observe({K_CHG, changeAmount});
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input logic cv, input logic [1:0] cc, input logic [3:0] btn,
                       input logic bd, input logic rf);
    coinValid = cv;
    coinValue = cc;
    buttonSel = btn;
    brewDone  = bd;
    refundReq = rf;
    tick();
    coinValid = 1'b0;
    coinValue = 2'b00;
    buttonSel = 4'd0;
    brewDone  = 1'b0;
    refundReq = 1'b0;
  endtask

  task automatic coin(input logic [1:0] cc);
    drive(1'b1, cc, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic press(input logic [3:0] btn);
    drive(1'b0, 2'b00, btn, 1'b0, 1'b0);
  endtask

  task automatic brew();
    drive(1'b0, 2'b00, 4'd0, 1'b1, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    Reset_n   = 1'b0;
    coinValid = 1'b1;
    coinValue = 2'b11;
    buttonSel = 4'd0;
    brewDone  = 1'b0;
    refundReq = 1'b0;

    // Reset held two cycles with a coin present.
    tick();
    tick();
    check("rst_credit", credit, 0);
    check("rst_sel", cofeeSelection, 0);
    check("rst_busy", busy, 0);
    check("rst_change_amount", changeAmount, 0);
    check("rst_state", o_dbg_state, S_IDLE);
    check("rst_pulses", {coinReject, lowCredit, changeValid}, 0);
    Reset_n   = 1'b1;
    coinValid = 1'b0;
    coinValue = 2'b00;

    // Coins 10, 5, 2 then latte.
    coin(2'b11); check("credit_after_10", credit, 10);
    coin(2'b10); check("credit_after_5", credit, 15);
    coin(2'b01); check("credit_after_2", credit, 17);
    press(4'b0010);
    check("latte_sel", cofeeSelection, 4'b0010);
    check("latte_credit", credit, 2);
    check("latte_busy", busy, 1);
    check("latte_state", o_dbg_state, S_DISPENSE);
    tick();
    check("latte_sel_held", cofeeSelection, 4'b0010);
    brew();
    check("brewdone_sel", cofeeSelection, 0);
    check("brewdone_state", o_dbg_state, S_CHANGE);
    check("brewdone_busy", busy, 1);
    expect_ev(K_CHG, 2);
    tick();
    check("change_credit", credit, 0);
    check("change_state", o_dbg_state, S_IDLE);
    check("change_busy", busy, 0);
    check("change_amount", changeAmount, 2);
    tick();
    check("change_amount_held", changeAmount, 2);

    // Insufficient credit, with and without a coin in the same cycle.
    coin(2'b10); check("credit_5", credit, 5);
    expect_ev(K_LOW, 5);
    press(4'b1000);
    check("low_credit_kept", credit, 5);
    check("low_sel", cofeeSelection, 0);
    check("low_state", o_dbg_state, S_IDLE);
    expect_ev(K_LOW, 7);
    drive(1'b1, 2'b01, 4'b1000, 1'b0, 1'b0);
    check("low_with_coin_credit", credit, 7);
    coin(2'b11); coin(2'b00); coin(2'b01);
    check("credit_20", credit, 20);
    press(4'b0011);
    check("multi_button_credit", credit, 20);
    check("multi_button_state", o_dbg_state, S_IDLE);

    // Credit ceiling.
    coin(2'b11); coin(2'b11); coin(2'b10);
    check("credit_45", credit, 45);
    coin(2'b10);
    check("credit_max", credit, 50);
    expect_ev(K_REJ, 50);
    coin(2'b00);
    check("over_max_credit", credit, 50);

    // Mocca, coin during DISPENSE, coin during CHANGE.
    press(4'b1000);
    check("mocca_sel", cofeeSelection, 4'b1000);
    check("mocca_credit", credit, 30);
    expect_ev(K_REJ, 30);
    coin(2'b11);
    check("dispense_coin_credit", credit, 30);
    check("dispense_sel_held", cofeeSelection, 4'b1000);
    brew();
    check("mocca_change_state", o_dbg_state, S_CHANGE);
    expect_ev(K_REJ, 0);
    expect_ev(K_CHG, 30);
    coin(2'b01);
    check("change_coin_credit", credit, 0);
    check("change_coin_amount", changeAmount, 30);
    check("change_coin_state", o_dbg_state, S_IDLE);

    // Drink plus coin in the same cycle; zero credit at CHANGE.
    coin(2'b11);
    expect_ev(K_REJ, 0);
    drive(1'b1, 2'b11, 4'b0001, 1'b0, 1'b0);
    check("expresso_sel", cofeeSelection, 4'b0001);
    check("expresso_credit", credit, 0);
    check("expresso_state", o_dbg_state, S_DISPENSE);
    brew();
    tick();
    check("zero_change_state", o_dbg_state, S_IDLE);
    check("zero_change_amount_kept", changeAmount, 30);
    brew();
    check("idle_brewdone_state", o_dbg_state, S_IDLE);
    check("idle_brewdone_sel", cofeeSelection, 0);

    // Reset in the middle of DISPENSE.
    coin(2'b11); coin(2'b11);
    press(4'b0001);
    check("pre_reset_state", o_dbg_state, S_DISPENSE);
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    check("mid_reset_sel", cofeeSelection, 0);
    check("mid_reset_credit", credit, 0);
    check("mid_reset_amount", changeAmount, 0);
    check("mid_reset_state", o_dbg_state, S_IDLE);
    brew();
    tick();
    check("post_reset_state", o_dbg_state, S_IDLE);

`ifdef COFFEE_REFUND_EN
    coin(2'b11); coin(2'b10); coin(2'b01);
    check("refund_credit_17", credit, 17);
    expect_ev(K_REJ, 0);
    expect_ev(K_CHG, 17);
    drive(1'b1, 2'b01, 4'b0001, 1'b0, 1'b1);
    check("refund_credit", credit, 0);
    check("refund_sel", cofeeSelection, 0);
    check("refund_state", o_dbg_state, S_IDLE);
    check("refund_amount", changeAmount, 17);
    drive(1'b0, 2'b00, 4'd0, 1'b0, 1'b1);
    check("refund_zero_amount", changeAmount, 17);
    check("refund_zero_state", o_dbg_state, S_IDLE);
`endif

    tick();
    tick();
    check("pending_events", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
